jt12_mix: RTL and testbench
===========================

JT12_MIX -- requirements
Module: jt12_mix

Interface
REQ-001 Parameter CH, default 4, number of mixed input channels (1..16).
REQ-002 Parameter W, default 16, signed width of each input sample.
REQ-003 Parameter GW, default 8, unsigned gain width; gain 2^(GW-1) is unity.
REQ-004 Parameter OW, default 16, signed width of each output sample.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 cen  in  1  clock enable; state advances only on clk edges with cen=1.
REQ-008 sample  in  1  new-input strobe, sampled when cen=1.
REQ-009 ch_in  in  CH*W  signed channel samples; channel k at bits [k*W +: W].
REQ-010 gain_l  in  CH*GW  unsigned left gains, same packing.
REQ-011 gain_r  in  CH*GW  unsigned right gains, same packing.
REQ-012 mute  in  CH  bit k=1 forces channel k contribution to 0.
REQ-013 snd_left  out  OW  signed mixed left sample.
REQ-014 snd_right  out  OW  signed mixed right sample.
REQ-015 snd_sample  out  1  one-clk pulse when snd_left/snd_right update.
REQ-016 clip_l, clip_r  out  1 each  saturation flags for the current output sample.
REQ-017 overrun  out  1  one-clk pulse when a sample strobe is dropped.

Function
REQ-018 States: IDLE, ACC, DONE; transitions only on cen=1 edges.
REQ-019 IDLE + sample=1: snapshot ch_in, gain_l, gain_r, mute; clear both accumulators; index=0; go ACC.
REQ-020 ACC: per cen edge add (ch_in[index]*gain)>>>0 to each accumulator (0 if muted); index increments; after index CH-1 go DONE.
REQ-021 Accumulator width W+GW+ceil(log2(CH))+1 signed; no internal overflow.
REQ-022 DONE: arithmetic shift right by GW-1 (floor), saturate to [-2^(OW-1), 2^(OW-1)-1], register snd_left/snd_right/clip_l/clip_r, pulse snd_sample, go IDLE.
REQ-023 Latency: snd_sample asserts on the (CH+2)th cen edge counting the strobe edge as 1.
REQ-024 sample=1 in ACC or DONE: strobe ignored, overrun pulses one clk, in-progress mix unaffected.
REQ-025 Input changes after snapshot have no effect on the current mix.
REQ-026 clip_x=1 iff that channel's pre-saturation value was out of range; held until next DONE.
REQ-027 snd_sample and overrun are single-clk pulses even when cen stays high.
REQ-028 Outputs hold last value between updates.

Reset
REQ-029 rst_n=0 asynchronously: state IDLE, index 0, accumulators 0, snd_left/snd_right 0, snd_sample/clip_l/clip_r/overrun 0.
REQ-030 Reset mid-ACC discards the partial mix; no snd_sample until a new strobe completes.

Structure
REQ-031 Package jt12_mix_pkg holds the state enum and the accumulator-width constant function.
REQ-032 Sub-module jt12_mix_sat (parametrised shift+saturate with clip flag) instantiated once per side.

Verification (CH=4, W=16, GW=8, OW=16, cen=1)
REQ-033 ch_in={0,0,0,1000}, all gains 128 -> snd_left=snd_right=1000, snd_sample 6 cycles after strobe, clips 0.
REQ-034 ch_in={300,-500,2000,1000}, gains 128 -> 2800 both sides; mute=4'b0010 -> 800.
REQ-035 ch_in ch0=-1001, gain_l0=64, gain_r0=255 others 0 -> snd_left=-501, snd_right=-1995.
REQ-036 All ch_in=30000, gains 255 -> 32767, clip=1; all -30000 -> -32768, clip=1.
REQ-037 Second strobe 2 cycles after first -> overrun pulse, one snd_sample with first result only.
REQ-038 rst_n low during ACC -> all outputs 0 immediately, no snd_sample; next strobe mixes correctly.

Source files
------------

// File: rtl/jt12_mix_pkg.sv
// rtl/jt12_mix_pkg.sv - shared types and sizing helpers for the stereo channel mixer
package jt12_mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } mix_state_e;

  // Sized so that CH full-scale signed*unsigned products can never overflow the sum.
  function automatic int acc_width(input int ch, input int w, input int gw);
    return w + gw + $clog2(ch) + 1;
  endfunction

endpackage

// File: rtl/jt12_mix_sat.sv
// rtl/jt12_mix_sat.sv - arithmetic right shift followed by signed saturation with clip flag
module jt12_mix_sat #(
  parameter int IW = 27,
  parameter int SH = 7,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] din_i,
  output logic signed [OW-1:0] dout_o,
  output logic                 clip_o
);

  logic signed [IW-1:0] shifted;

  assign shifted = din_i >>> SH;

  // The value fits in OW bits exactly when every bit from OW-1 upward matches the sign.
  assign clip_o = (shifted[IW-1:OW-1] != {(IW-OW+1){shifted[IW-1]}});

  assign dout_o = clip_o ? (shifted[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}})
                         : shifted[OW-1:0];

endmodule

// File: rtl/jt12_mix.sv
// rtl/jt12_mix.sv - sequential per-channel gain/mute stereo mixer with saturation and overrun flag
module jt12_mix
  import jt12_mix_pkg::*;
#(
  parameter int CH = 4,
  parameter int W  = 16,
  parameter int GW = 8,
  parameter int OW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 sample,
  input  logic [CH*W-1:0]      ch_in,
  input  logic [CH*GW-1:0]     gain_l,
  input  logic [CH*GW-1:0]     gain_r,
  input  logic [CH-1:0]        mute,
  output logic signed [OW-1:0] snd_left,
  output logic signed [OW-1:0] snd_right,
  output logic                 snd_sample,
  output logic                 clip_l,
  output logic                 clip_r,
  output logic                 overrun
);

  localparam int AW  = acc_width(CH, W, GW);
  localparam int IXW = (CH > 1) ? $clog2(CH) : 1;

  mix_state_e            state_q, state_d;
  logic [IXW-1:0]        idx_q, idx_d;
  logic [CH*W-1:0]       ch_q, ch_d;
  logic [CH*GW-1:0]      gl_q, gl_d;
  logic [CH*GW-1:0]      gr_q, gr_d;
  logic [CH-1:0]         mute_q, mute_d;
  logic signed [AW-1:0]  acc_l_q, acc_l_d;
  logic signed [AW-1:0]  acc_r_q, acc_r_d;
  logic signed [OW-1:0]  left_q, left_d;
  logic signed [OW-1:0]  right_q, right_d;
  logic                  clip_l_q, clip_l_d;
  logic                  clip_r_q, clip_r_d;
  logic                  smp_q, smp_d;
  logic                  ovr_q, ovr_d;

  logic signed [W-1:0]   cur_ch;
  logic [GW-1:0]         cur_gl;
  logic [GW-1:0]         cur_gr;
  logic                  cur_mute;
  logic signed [AW-1:0]  prod_l;
  logic signed [AW-1:0]  prod_r;
  logic signed [OW-1:0]  sat_l;
  logic signed [OW-1:0]  sat_r;
  logic                  sat_clip_l;
  logic                  sat_clip_r;

  always_comb begin
    cur_ch   = '0;
    cur_gl   = '0;
    cur_gr   = '0;
    cur_mute = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (idx_q == IXW'(k)) begin
        cur_ch   = ch_q[k*W +: W];
        cur_gl   = gl_q[k*GW +: GW];
        cur_gr   = gr_q[k*GW +: GW];
        cur_mute = mute_q[k];
      end
    end
  end

  // Gains are unsigned: widen with a zero MSB before the signed multiply.
  assign prod_l = cur_mute ? '0 : AW'(cur_ch) * AW'($signed({1'b0, cur_gl}));
  assign prod_r = cur_mute ? '0 : AW'(cur_ch) * AW'($signed({1'b0, cur_gr}));

  jt12_mix_sat #(.IW(AW), .SH(GW-1), .OW(OW)) u_sat_l (
    .din_i  (acc_l_q),
    .dout_o (sat_l),
    .clip_o (sat_clip_l)
  );

  jt12_mix_sat #(.IW(AW), .SH(GW-1), .OW(OW)) u_sat_r (
    .din_i  (acc_r_q),
    .dout_o (sat_r),
    .clip_o (sat_clip_r)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ch_d     = ch_q;
    gl_d     = gl_q;
    gr_d     = gr_q;
    mute_d   = mute_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    left_d   = left_q;
    right_d  = right_q;
    clip_l_d = clip_l_q;
    clip_r_d = clip_r_q;
    smp_d    = 1'b0;
    ovr_d    = 1'b0;
    if (cen) begin
      case (state_q)
        ST_IDLE: begin
          if (sample) begin
            ch_d    = ch_in;
            gl_d    = gain_l;
            gr_d    = gain_r;
            mute_d  = mute;
            acc_l_d = '0;
            acc_r_d = '0;
            idx_d   = '0;
            state_d = ST_ACC;
          end
        end
        ST_ACC: begin
          ovr_d   = sample;
          acc_l_d = acc_l_q + prod_l;
          acc_r_d = acc_r_q + prod_r;
          if (idx_q == IXW'(CH-1)) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          ovr_d    = sample;
          left_d   = sat_l;
          right_d  = sat_r;
          clip_l_d = sat_clip_l;
          clip_r_d = sat_clip_r;
          smp_d    = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      ch_q     <= '0;
      gl_q     <= '0;
      gr_q     <= '0;
      mute_q   <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      left_q   <= '0;
      right_q  <= '0;
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
      smp_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ch_q     <= ch_d;
      gl_q     <= gl_d;
      gr_q     <= gr_d;
      mute_q   <= mute_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      left_q   <= left_d;
      right_q  <= right_d;
      clip_l_q <= clip_l_d;
      clip_r_q <= clip_r_d;
      smp_q    <= smp_d;
      ovr_q    <= ovr_d;
    end
  end

  assign snd_left   = left_q;
  assign snd_right  = right_q;
  assign snd_sample = smp_q;
  assign clip_l     = clip_l_q;
  assign clip_r     = clip_r_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_jt12_mix.sv
// tb/tb_jt12_mix.sv - randomized self-checking bench for jt12_mix against an arithmetic mix model
module tb_jt12_mix;
  localparam int CH = 4;
  localparam int W  = 16;
  localparam int GW = 8;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cen = 1'b1;
  logic                 sample = 1'b0;
  logic [CH*W-1:0]      ch_in = '0;
  logic [CH*GW-1:0]     gain_l = '0;
  logic [CH*GW-1:0]     gain_r = '0;
  logic [CH-1:0]        mute = '0;
  logic signed [OW-1:0] snd_left;
  logic signed [OW-1:0] snd_right;
  logic                 snd_sample;
  logic                 clip_l;
  logic                 clip_r;
  logic                 overrun;

  int n_vec = 0;
  int n_bad = 0;

  jt12_mix #(.CH(CH), .W(W), .GW(GW), .OW(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .sample     (sample),
    .ch_in      (ch_in),
    .gain_l     (gain_l),
    .gain_r     (gain_r),
    .mute       (mute),
    .snd_left   (snd_left),
    .snd_right  (snd_right),
    .snd_sample (snd_sample),
    .clip_l     (clip_l),
    .clip_r     (clip_r),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Mixing rule: sum of sample*gain over unmuted channels, floor-divided by unity gain, then clamped.
  function automatic void ref_side(input logic [CH*W-1:0] chv, input logic [CH*GW-1:0] gv,
                                   input logic [CH-1:0] mv, output longint val, output longint clip);
    longint sum;
    longint unity;
    longint hi;
    longint lo;
    sum   = 0;
    unity = longint'(1) << (GW-1);
    hi    = (longint'(1) << (OW-1)) - 1;
    lo    = -(longint'(1) << (OW-1));
    for (int k = 0; k < CH; k++) begin
      if (!mv[k]) sum += longint'($signed(chv[k*W +: W])) * longint'(gv[k*GW +: GW]);
    end
    val = sum / unity;
    if ((val * unity) > sum) val = val - 1;
    clip = 0;
    if (val > hi) begin val = hi; clip = 1; end
    if (val < lo) begin val = lo; clip = 1; end
  endfunction

  function automatic logic [CH*W-1:0] pack_ch(input int a3, input int a2, input int a1, input int a0);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic strobe(input logic [CH*W-1:0] chv, input logic [CH*GW-1:0] glv,
                        input logic [CH*GW-1:0] grv, input logic [CH-1:0] mv);
    ch_in = chv; gain_l = glv; gain_r = grv; mute = mv;
    sample = 1'b1; cen = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    ch_in  = {$urandom, $urandom};
    gain_l = $urandom;
    gain_r = $urandom;
    mute   = 4'($urandom);
  endtask

  task automatic run_mix(input logic [CH*W-1:0] chv, input logic [CH*GW-1:0] glv,
                         input logic [CH*GW-1:0] grv, input logic [CH-1:0] mv, input bit rnd_cen);
    longint el, er, cl, cr;
    int cen_edges;
    bit seen;
    ref_side(chv, glv, mv, el, cl);
    ref_side(chv, grv, mv, er, cr);
    strobe(chv, glv, grv, mv);
    cen_edges = 1;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      cen = rnd_cen ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      if (cen) cen_edges++;
      #1;
      seen = snd_sample;
    end
    chk("done_seen", seen, 1);
    chk("latency", cen_edges, CH+2);
    chk("left", snd_left, el);
    chk("right", snd_right, er);
    chk("clip_l", clip_l, cl);
    chk("clip_r", clip_r, cr);
    cen = rnd_cen ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    chk("pulse_low", snd_sample, 0);
    chk("hold_left", snd_left, el);
    cen = 1'b1;
  endtask

  initial begin
    logic [CH*W-1:0]  chv;
    logic [CH*W-1:0]  chb;
    logic [CH*GW-1:0] glv;
    logic [CH*GW-1:0] grv;
    logic [CH-1:0]    mv;
    longint el, er, cl, cr, dl, dr;
    int pulses;

    #12;
    chk("rst_left", snd_left, 0);
    chk("rst_right", snd_right, 0);
    chk("rst_sample", snd_sample, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_mix(pack_ch(0, 0, 0, 1000), {4{8'd128}}, {4{8'd128}}, 4'b0000, 1'b0);
    run_mix(pack_ch(300, -500, 2000, 1000), {4{8'd128}}, {4{8'd128}}, 4'b0000, 1'b0);
    run_mix(pack_ch(300, -500, 2000, 1000), {4{8'd128}}, {4{8'd128}}, 4'b0010, 1'b0);
    run_mix(pack_ch(0, 0, 0, -1001), {24'd0, 8'd64}, {24'd0, 8'd255}, 4'b0000, 1'b0);
    run_mix(pack_ch(30000, 30000, 30000, 30000), {4{8'd255}}, {4{8'd255}}, 4'b0000, 1'b0);
    run_mix(pack_ch(-30000, -30000, -30000, -30000), {4{8'd255}}, {4{8'd255}}, 4'b0000, 1'b0);
    run_mix(pack_ch(-1, -1, -1, -1), {4{8'd1}}, {4{8'd0}}, 4'b0000, 1'b0);

    for (int t = 0; t < 24; t++) begin
      chv = {$urandom, $urandom};
      glv = $urandom;
      grv = $urandom;
      mv  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      run_mix(chv, glv, grv, mv, t[0]);
    end

    chv = pack_ch(1234, -4321, 777, 9000);
    glv = {8'd10, 8'd200, 8'd128, 8'd90};
    grv = {8'd255, 8'd3, 8'd64, 8'd128};
    ref_side(chv, glv, 4'b0100, el, cl);
    ref_side(chv, grv, 4'b0100, er, cr);
    strobe(chv, glv, grv, 4'b0100);
    chk("no_ovr_idle", overrun, 0);
    @(posedge clk); #1;
    sample = 1'b1;
    ch_in  = pack_ch(-20000, 20000, -20000, 20000);
    gain_l = {4{8'd255}};
    @(posedge clk); #1;
    chk("ovr_pulse", overrun, 1);
    sample = 1'b0;
    @(posedge clk); #1;
    chk("ovr_low", overrun, 0);
    pulses = 0;
    dl = 0; dr = 0;
    for (int i = 0; i < 15; i++) begin
      if (snd_sample) begin pulses++; dl = snd_left; dr = snd_right; end
      @(posedge clk); #1;
    end
    chk("ovr_pulses", pulses, 1);
    chk("ovr_left", dl, el);
    chk("ovr_right", dr, er);

    run_mix(pack_ch(30000, 30000, 30000, 30000), {4{8'd255}}, {4{8'd255}}, 4'b0000, 1'b0);
    chb = pack_ch(100, 200, 300, 400);
    strobe(chb, {4{8'd128}}, {4{8'd128}}, 4'b0000);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_left", snd_left, 0);
    chk("arst_right", snd_right, 0);
    chk("arst_clip_l", clip_l, 0);
    chk("arst_clip_r", clip_r, 0);
    chk("arst_sample", snd_sample, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (snd_sample) pulses++;
    end
    chk("arst_no_sample", pulses, 0);
    run_mix(chb, {4{8'd128}}, {4{8'd128}}, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
